turn_sequencer: RTL
===================

Name: turn_sequencer

Overview:
- Parametrised N-player turn controller for the connect-four game; generalises the two-player alternator.
- Takes the shared enter button plus a legality verdict from the board logic. Commits one move per turn, rotates the active player round-robin and counts moves.
- Skips a stalled player on timeout. Halts on game over until a new game is requested.
- Sits between the input debouncer/synchroniser and the board/display logic.

Parameters:
- NUM_PLAYERS, 2, number of players in rotation; legal range 2..8.
- TIMEOUT_CYCLES, 1000, clk cycles a player may idle in a turn before being skipped; minimum 2.
- CNT_W, 6, width of the move counter; 6 covers 42 moves.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enter  input  1  move button, already debounced and synchronised; a move is a rising edge.
- move_legal  input  1  board logic verdict for the pending column, valid in the same cycle as enter.
- game_over  input  1  level from the win/draw detector.
- new_game  input  1  level; leaves HALT.
- player_id  output  $clog2(NUM_PLAYERS)  index of the active player.
- leds  output  NUM_PLAYERS  one-hot of player_id; all ones in HALT.
- move_commit  output  1  one-cycle pulse: the move is accepted for player_id.
- move_illegal  output  1  one-cycle pulse: an illegal press was rejected.
- timeout  output  1  one-cycle pulse: the active player was skipped.
- turn_count  output  CNT_W  committed moves since reset or new_game; saturates at all ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=TURN, player_id=0, leds=0...01.
  - move_commit, move_illegal and timeout = 0.
  - turn_count=0, idle timer=0, enter_q=0.
  - Reset asserted mid-operation aborts any pending commit; no pulse is emitted.
- Edge detect: enter_q <= enter every edge; press = enter & ~enter_q.
  - A held button produces exactly one press.
- States: TURN, COMMIT, HALT.
- TURN:
  - game_over=1 -> HALT next edge. This has priority over press and timeout.
  - press & move_legal -> COMMIT; move_commit=1 for exactly the COMMIT cycle.
  - press & ~move_legal -> stay in TURN; move_illegal=1 for one cycle; timer not cleared.
  - No press: the timer increments each cycle.
  - Timer reaching TIMEOUT_CYCLES-1 -> timeout=1 for one cycle; player_id advances; timer=0; turn_count unchanged.
  - A press in the same cycle as the timeout wins: the move is committed and there is no timeout pulse.
- COMMIT (exactly one cycle):
  - At the exiting edge: player_id <= (player_id==NUM_PLAYERS-1) ? 0 : player_id+1.
  - turn_count += 1, saturating; timer=0.
  - Next state is HALT if game_over=1, else TURN.
  - enter is ignored during COMMIT.
- Latency: enter high before edge k -> move_commit high from edge k to k+1 -> new player_id visible after edge k+1.
- HALT:
  - leds all ones; player_id holds the last value, so the last committer is readable.
  - enter is ignored, timer frozen, no pulses.
  - new_game=1 -> TURN with player_id=0, turn_count=0, timer=0.
  - new_game has no effect outside HALT.
- At most one of move_commit, move_illegal and timeout is high in any cycle.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined: the idle timer and timeout behaviour are as above.
- Undefined:
  - No timer logic is synthesised; timeout is tied to 0.
  - A player holds the turn indefinitely.
  - TIMEOUT_CYCLES is ignored.

Test Plan:
- NUM_PLAYERS=3. Reset, then three legal presses spaced 4 cycles apart -> player_id 0->1->2->0; leds 001->010->100->001; three single-cycle move_commit pulses; turn_count=3.
- Hold enter high for 10 cycles with move_legal=1 -> exactly one move_commit; player_id advances once; turn_count=1.
- Press with move_legal=0 -> move_illegal pulse; player_id unchanged; turn_count unchanged; no move_commit.
- TURN_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no input for 8 cycles -> timeout pulse on the 8th cycle; player_id 0->1; turn_count stays 0. Without the macro, 100 idle cycles -> no timeout, player_id stays 0.
- Legal press with game_over=1 in the COMMIT cycle -> HALT; leds all ones; further presses ignored. Assert new_game -> TURN, player_id=0, turn_count=0.
- Assert reset low asynchronously during COMMIT -> outputs return to reset values immediately with no clock edge; no commit pulse after release. Drive CNT_W=2 with 5 commits -> turn_count saturates at 3.

Source files
------------

// File: rtl/turn_sequencer.sv
// N-player round-robin turn controller: commits one move per turn, counts moves and halts on game over.
// Optional idle-player skip is built only when TURN_TIMEOUT_EN is defined; otherwise timeout is tied low.
module turn_sequencer #(
  parameter int NUM_PLAYERS    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enter,
  input  logic                           move_legal,
  input  logic                           game_over,
  input  logic                           new_game,
  output logic [$clog2(NUM_PLAYERS)-1:0] player_id,
  output logic [NUM_PLAYERS-1:0]         leds,
  output logic                           move_commit,
  output logic                           move_illegal,
  output logic                           timeout,
  output logic [CNT_W-1:0]               turn_count
);

  localparam int PW = $clog2(NUM_PLAYERS);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("turn_sequencer: NUM_PLAYERS must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {
    TURN   = 2'd0,
    COMMIT = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              enter_q;
  logic              press;
  logic              timer_done;
  logic [PW-1:0]     pid_inc, pid_nx;
  logic [CNT_W-1:0]  cnt_sat, cnt_nx;
  logic              illegal_nx, timeout_nx;

  assign press   = enter & ~enter_q;
  assign pid_inc = (player_id == PW'(NUM_PLAYERS - 1)) ? '0 : player_id + 1'b1;
  assign cnt_sat = (&turn_count) ? turn_count : turn_count + 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx   = state;
    pid_nx     = player_id;
    cnt_nx     = turn_count;
    illegal_nx = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      TURN: begin
        if (game_over) begin
          state_nx = HALT;
        end else if (press && move_legal) begin
          state_nx = COMMIT;
        end else if (press) begin
          illegal_nx = 1'b1;
        end else if (timer_done) begin
          timeout_nx = 1'b1;
          pid_nx     = pid_inc;
        end
      end
      COMMIT: begin
        pid_nx   = pid_inc;
        cnt_nx   = cnt_sat;
        state_nx = game_over ? HALT : TURN;
      end
      HALT: begin
        if (new_game) begin
          state_nx = TURN;
          pid_nx   = '0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = TURN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset clears every register immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= TURN;
      player_id    <= '0;
      turn_count   <= '0;
      enter_q      <= 1'b0;
      move_illegal <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      player_id    <= pid_nx;
      turn_count   <= cnt_nx;
      enter_q      <= enter;
      move_illegal <= illegal_nx;
      timeout      <= timeout_nx;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;

  assign timer_done = (timer == TW'(TIMEOUT_CYCLES - 1));

  // Idle timer runs only in TURN with no press; a rejected press leaves it where it was.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == TURN) begin
      if (!game_over && !press) begin
        timer <= timer_done ? '0 : timer + 1'b1;
      end
    end else if (state == COMMIT || new_game) begin
      timer <= '0;
    end
  end
`else
  assign timer_done = 1'b0;
`endif

  assign move_commit = (state == COMMIT);
  assign leds = (state == HALT) ? '1
                                : ({{(NUM_PLAYERS-1){1'b0}}, 1'b1} << player_id);

endmodule
